jpc_fetch: RTL

Instruction-fetch sequencer that drives the PC register's update port: produces next_pc_O/pc_enable_O, which the PC register consumes as next_pc_I/pc_enable_I.
- Issues one instruction-memory request per current PC over a valid/ready channel.
- Buffers returned words with their PC in a small queue for decode.
- Handles branch/jump redirects, including discarding in-flight stale responses.

---
 rtl/jpc_pkg.sv | 28 ++
 rtl/jpc_fetch_if.sv | 44 ++++
 rtl/jpc_fetch_fifo.sv | 56 +++++
 rtl/jpc_fetch.sv | 110 +++++++++++
 4 files changed

// File: rtl/jpc_pkg.sv
// Shared types and constants for the jpc instruction-fetch sequencer.
// Default address width comes from JPC_ADDRESS_WIDTH when not set externally.
`ifndef JPC_ADDRESS_WIDTH
`define JPC_ADDRESS_WIDTH 32
`endif

package jpc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } fetch_state_t;

    localparam int JPC_PC_INC = 4;
    localparam int JPC_ADDR_W = `JPC_ADDRESS_WIDTH;
    localparam int JPC_DATA_W = 32;

    typedef struct packed {
        logic [JPC_ADDR_W-1:0] pc;
        logic [JPC_DATA_W-1:0] instr;
    } iq_entry_t;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/jpc_fetch_if.sv
// Fetch-side channels: instruction-memory request/response and the
// decode-facing instruction queue head.
`ifndef JPC_ADDRESS_WIDTH
`define JPC_ADDRESS_WIDTH 32
`endif

interface jpc_fetch_if #(
    parameter int ADDR_W = `JPC_ADDRESS_WIDTH,
    parameter int DATA_W = 32
);
    logic              imem_req_valid_O;
    logic              imem_req_ready_I;
    logic [ADDR_W-1:0] imem_req_addr_O;
    logic              imem_rsp_valid_I;
    logic [DATA_W-1:0] imem_rsp_data_I;
    logic              instr_valid_O;
    logic              instr_ready_I;
    logic [DATA_W-1:0] instr_O;
    logic [ADDR_W-1:0] instr_pc_O;

    modport master (
        output imem_req_valid_O,
        output imem_req_addr_O,
        input  imem_req_ready_I,
        input  imem_rsp_valid_I,
        input  imem_rsp_data_I,
        output instr_valid_O,
        output instr_O,
        output instr_pc_O,
        input  instr_ready_I
    );

    modport slave (
        input  imem_req_valid_O,
        input  imem_req_addr_O,
        output imem_req_ready_I,
        output imem_rsp_valid_I,
        output imem_rsp_data_I,
        input  instr_valid_O,
        input  instr_O,
        input  instr_pc_O,
        output instr_ready_I
    );
endinterface

// File: rtl/jpc_fetch_fifo.sv
// Small synchronous instruction queue with flush; flush wins over push/pop.
// Pointers wrap naturally because DEPTH is a power of two.
module jpc_fetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  logic [W-1:0]  i_wdata,
    output logic [W-1:0]  o_rdata,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rp];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            if (w_push & ~w_pop)
                r_count <= r_count + 1'b1;
            else if (w_pop & ~w_push)
                r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push & ~i_flush) r_mem[r_wp] <= i_wdata;
    end
endmodule

// File: rtl/jpc_fetch.sv
// Instruction-fetch sequencer: one outstanding request per PC, redirect flush.
// Define JPC_FETCH_BYTESWAP_EN to byte-reverse words from big-endian memory.
`ifndef JPC_ADDRESS_WIDTH
`define JPC_ADDRESS_WIDTH 32
`endif

module jpc_fetch
    import jpc_pkg::*;
#(
    parameter int ADDR_W = `JPC_ADDRESS_WIDTH,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    parameter int PC_INC = JPC_PC_INC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_I,
    output logic [ADDR_W-1:0] next_pc_O,
    output logic              pc_enable_O,
    input  logic              redirect_I,
    input  logic [ADDR_W-1:0] redirect_pc_I,
    jpc_fetch_if.master       bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = ADDR_W + DATA_W;

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_addr_q;

    logic [CW-1:0]     w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_req_valid;
    logic              w_hs;
    logic              w_rsp;
    logic              w_push;
    logic              w_pop;
    logic              w_instr_valid;
    logic [DATA_W-1:0] w_rsp_data;
    logic [EW-1:0]     w_rdata;

`ifdef JPC_FETCH_BYTESWAP_EN
    assign w_rsp_data = bswap32(bus.imem_rsp_data_I);
`else
    assign w_rsp_data = bus.imem_rsp_data_I;
`endif

    assign w_rsp       = bus.imem_rsp_valid_I;
    assign w_req_valid = ~rst & (r_state == IDLE)
                       & (w_count < CW'(DEPTH)) & ~redirect_I;
    assign w_hs        = w_req_valid & bus.imem_req_ready_I;

    assign bus.imem_req_valid_O = w_req_valid;
    assign bus.imem_req_addr_O  = pc_I;

    assign next_pc_O   = redirect_I ? redirect_pc_I
                                    : pc_I + ADDR_W'(PC_INC);
    assign pc_enable_O = ~rst & (redirect_I | w_hs);

    // Stale responses never reach the queue: only WAIT without redirect pushes
    assign w_push = (r_state == WAIT) & w_rsp & ~redirect_I & ~w_full;

    assign w_instr_valid     = ~rst & ~w_empty & ~redirect_I;
    assign w_pop             = w_instr_valid & bus.instr_ready_I;
    assign bus.instr_valid_O = w_instr_valid;
    assign bus.instr_pc_O    = w_rdata[EW-1:DATA_W];
    assign bus.instr_O       = w_rdata[DATA_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_addr_q <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_hs) begin
                        r_state  <= WAIT;
                        r_addr_q <= pc_I;
                    end
                end
                WAIT: begin
                    if (w_rsp)
                        r_state <= IDLE;
                    else if (redirect_I)
                        r_state <= DROP;
                end
                DROP: begin
                    if (w_rsp) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    jpc_fetch_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_I),
        .i_wdata ({r_addr_q, w_rsp_data}),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );
endmodule
